bus_ram_slave: RTL
==================

// Module: bus_ram_slave
// PURPOSE
//  AHB-Lite responder: word-organised RAM behind the bus decoder; serves ext_1 region [0, 2048).
//  Takes address phases from the shared slave-input bundle and returns rdata/ready/resp to the mux.
//  Byte/half/word reads and writes; ERROR response for misaligned or out-of-range accesses.
// PARAMETERS
//  BASE_ADDR    32'h0  byte address of word 0; offset = addr - BASE_ADDR
//  DEPTH_WORDS  512    RAM depth in 32-bit words (2048 bytes)
//  WAIT_CYCLES  2      wait states per OKAY transfer; used only with BUS_RAM_WAIT_EN
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  sel       in   1   decoder select, address-phase qualified
//  addr      in   32  byte address
//  write     in   1   1 = write, 0 = read
//  size      in   3   transfer_size (BYTE=0, HALF=1, WORD=2)
//  trans     in   2   transfer_kind (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
//  ready     in   1   bus-wide HREADY; an address phase is sampled only when 1
//  wdata     in   32  write data, valid in the data phase
//  rdata     out  32  read data
//  ready_out out  1   HREADYOUT
//  resp      out  1   transfer_response (OKAY=0, ERROR=1)
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, ready_out=1, resp=OKAY, rdata=0; RAM contents undefined, not cleared.
//  - Accept: sel && ready && trans in {NONSEQ, SEQ}. Register offset, write and size as data-phase regs.
//    burst, prot and mastlock are ignored.
//  - Error check at accept: size>WORD; HALF with offset[0]; WORD with offset[1:0]!=0; offset>=DEPTH_WORDS*4.
//  - FSM states: IDLE, DATA, ERR1, ERR2.
//  - IDLE: ready_out=1, resp=OKAY.
//    good accept -> DATA; bad accept -> ERR1; otherwise stay in IDLE.
//    IDLE/BUSY transfers or sel=0 get a zero-wait OKAY.
//  - DATA: ready_out=1 when the wait counter is 0 (always 0 without the macro); resp=OKAY.
//    On the cycle ready_out=1:
//      * Write: wdata lanes commit to RAM at this edge. Strobes: BYTE = lane offset[1:0], HALF = lanes offset[1]*2+{0,1}, WORD = all.
//      * Read: rdata = full word mem[offset>>2], read asynchronously from the registered address. The master selects lanes.
//    Then: new good accept -> DATA; new bad accept -> ERR1; otherwise -> IDLE.
//  - rdata=0 whenever the output is not a completing read.
//  - ERR1: ready_out=0, resp=ERROR -> ERR2.
//    ERR2: ready_out=1, resp=ERROR; accepts a new phase exactly like IDLE. Errored writes never touch RAM.
//  - Back-to-back write then read of the same word: the read returns the newly written data (write commits before the read data phase).
//  - Reset mid-transfer: the pending write is dropped; outputs return to reset values immediately.
// CONFIGURATION
//  BUS_RAM_WAIT_EN defined:
//    - At each good accept, the counter loads WAIT_CYCLES.
//    - In DATA: ready_out=0 while counter!=0, counter decrements by 1 per cycle.
//    - No address sampled while ready=0; ERROR path unchanged.
//    - WAIT_CYCLES=0 behaves as zero-wait.
//  BUS_RAM_WAIT_EN undefined: no counter logic; every OKAY transfer is zero-wait.
// STRUCTURE
//  Shared package bus_pkg:
//    - transfer_size, transfer_kind, transfer_response enums.
//    - function byte_strobe(size, addr[1:0]) -> [3:0].
//  Local: state enum {IDLE, DATA, ERR1, ERR2}.
//  Sub-module bus_ram_array: DEPTH_WORDS x 32, 4-bit byte-write strobe, asynchronous read port.
// TESTING
//  1. Reset asserted mid-DATA write to 0x10 -> ready_out=1, resp=OKAY, rdata=0; read 0x10 afterwards != new wdata.
//  2. WORD write 0xDEADBEEF @0x20, then WORD read @0x20 back-to-back -> rdata=0xDEADBEEF on 2nd data phase, OKAY.
//  3. BYTE write 0xAA @0x21 over 0x11223344 -> WORD read @0x20 returns 0x1122AA44; HALF write 0xBEEF @0x22 -> 0xBEEFAA44.
//  4. WORD read @0x02 and WORD read @0x800 -> each: one cycle ready_out=0/ERROR, then ready_out=1/ERROR; RAM unchanged.
//  5. IDLE, BUSY, and NONSEQ with sel=0 -> ready_out=1, resp=OKAY, no state change, no RAM write.
//  6. BUS_RAM_WAIT_EN, WAIT_CYCLES=2: NONSEQ read -> ready_out low for exactly 2 cycles, then data; ready=0 blocks re-sampling.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared AHB-Lite bus types and the byte-lane strobe helper used by bus responders.
package bus_pkg;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2
  } transfer_size_e;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } transfer_kind_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response_e;

  // Sizes above WORD yield no lanes; such transfers are rejected before they reach RAM.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (size == SZ_BYTE)      s = 4'b0001 << a;
    else if (size == SZ_HALF) s = a[1] ? 4'b1100 : 4'b0011;
    else if (size == SZ_WORD) s = 4'b1111;
    return s;
  endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Word-organised RAM with per-byte write strobes and an asynchronous read port.
module bus_ram_array #(
  parameter int unsigned DEPTH_WORDS = 512
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [3:0]                     strb_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/bus_ram_slave.sv
// AHB-Lite RAM responder with ERROR on misaligned/out-of-range accesses.
// Optional wait states per OKAY transfer are enabled with `define BUS_RAM_WAIT_EN.
module bus_ram_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [2:0]  size,
  input  logic [1:0]  trans,
  input  logic        ready,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready_out,
  output logic        resp
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_e;

  state_e        state_q, state_d;
  logic [AW+1:0] off_q, off_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;

  logic [31:0] offset, ram_rdata;
  logic        accept, bad, wait_zero, done, we;

  assign offset = addr - BASE_ADDR;
  assign accept = sel && ready && (trans == TR_NONSEQ || trans == TR_SEQ);

  always_comb begin
    bad = 1'b0;
    if (size > SZ_WORD)                               bad = 1'b1;
    if (size == SZ_HALF && offset[0])                 bad = 1'b1;
    if (size == SZ_WORD && offset[1:0] != 2'b00)      bad = 1'b1;
    if (offset >= 32'(DEPTH_WORDS * 4))               bad = 1'b1;
  end

`ifdef BUS_RAM_WAIT_EN
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign wait_zero = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == DATA && !wait_zero)          cnt_d = cnt_q - 1'b1;
    else if (accept && !bad && state_q != ERR1) cnt_d = CW'(WAIT_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // WAIT_CYCLES has no effect in this build: every OKAY transfer is zero-wait.
  assign wait_zero = 1'b1 || (WAIT_CYCLES == 0);
`endif

  always_comb begin
    ready_out = 1'b1;
    resp      = RESP_OKAY;
    unique case (state_q)
      DATA: ready_out = wait_zero;
      ERR1: begin ready_out = 1'b0; resp = RESP_ERROR; end
      ERR2: resp = RESP_ERROR;
      default: ;
    endcase
  end

  assign done  = (state_q == DATA) && wait_zero;
  assign we    = done && write_q && !rst;
  assign rdata = (done && !write_q) ? ram_rdata : 32'h0;

  // A new address phase is taken only when the current one is not stalling.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    write_d = write_q;
    size_d  = size_q;
    if (state_q == ERR1) begin
      state_d = ERR2;
    end else if (state_q != DATA || wait_zero) begin
      state_d = IDLE;
      if (accept) begin
        state_d = bad ? ERR1 : DATA;
        off_d   = offset[AW+1:0];
        write_d = write;
        size_d  = size;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  bus_ram_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .strb_i  (byte_strobe(size_q, off_q[1:0])),
    .addr_i  (off_q[AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (ram_rdata)
  );

endmodule
